// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite plotter: FSM state encoding,
// default sprite/screen geometry and key-glyph ids.
package sprite_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAW  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_SPR_W    = 16;
   localparam int DEF_SPR_H    = 16;
   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;

   localparam logic [1:0] KEY_A = 2'd0;
   localparam logic [1:0] KEY_S = 2'd1;
   localparam logic [1:0] KEY_D = 2'd2;
   localparam logic [1:0] KEY_F = 2'd3;

endpackage

// File: rtl/sprite_plotter_coord_delay.sv
// coord_delay: LATENCY-deep shift register carrying {valid, px, py} so pixel
// coordinates line up with the colour returned by the image ROM stage.
module coord_delay #(
   parameter int LATENCY = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       vld_i,
   input  logic [8:0] px_i,
   input  logic [8:0] py_i,
   output logic       vld_o,
   output logic [8:0] px_o,
   output logic [8:0] py_o
);

   logic       vld_q [LATENCY];
   logic [8:0] px_q  [LATENCY];
   logic [8:0] py_q  [LATENCY];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < LATENCY; s++) begin
            vld_q[s] <= 1'b0;
            px_q[s]  <= '0;
            py_q[s]  <= '0;
         end
      end else begin
         vld_q[0] <= vld_i;
         px_q[0]  <= px_i;
         py_q[0]  <= py_i;
         for (int s = 1; s < LATENCY; s++) begin
            vld_q[s] <= vld_q[s-1];
            px_q[s]  <= px_q[s-1];
            py_q[s]  <= py_q[s-1];
         end
      end
   end

   assign vld_o = vld_q[LATENCY-1];
   assign px_o  = px_q[LATENCY-1];
   assign py_o  = py_q[LATENCY-1];

endmodule

// File: rtl/sprite_plotter.sv
// Scans a 16x16 sprite through the image ROM stage and plots it, clipped, on
// the VGA adapter. Define SPRITE_PLOTTER_TRANSPARENT_EN to skip black pixels.
module sprite_plotter
   import sprite_pkg::*;
#(
   parameter int LATENCY  = 2,
   parameter int SPR_W    = DEF_SPR_W,
   parameter int SPR_H    = DEF_SPR_H,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] x0,
   input  logic [7:0] y0,
   input  logic [2:0] frame,
   input  logic [1:0] key,
   input  logic [2:0] colour_in,
   output logic [2:0] img_id,
   output logic [1:0] img_id2,
   output logic [3:0] img_i,
   output logic [5:0] img_j,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam int DW = $clog2(LATENCY + 1);

   state_t        state_q, state_d;
   logic [7:0]    x0_q, y0_q;
   logic [2:0]    frame_q;
   logic [1:0]    key_q;
   logic [3:0]    i_q, j_q;
   logic [DW-1:0] drain_q;
   logic          accept, draw_vld, last_pix;
   logic [8:0]    px, py, px_dly, py_dly;
   logic          vld_dly;

   assign last_pix = (i_q == 4'(SPR_W - 1)) && (j_q == 4'(SPR_H - 1));

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = DRAW;
         DRAW:    if (last_pix) state_d = DRAIN;
         DRAIN:   if (drain_q == DW'(LATENCY - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept   = (state_q == IDLE) && start;
      draw_vld = (state_q == DRAW);
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
   end

   // Scan counters: i inner (column), j outer (row); drain counts ROM flush cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_q <= '0;
         key_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         drain_q <= '0;
      end else begin
         if (accept) begin
            frame_q <= frame;
            key_q   <= key;
            i_q     <= '0;
            j_q     <= '0;
         end else if (draw_vld) begin
            if (i_q == 4'(SPR_W - 1)) begin
               i_q <= '0;
               j_q <= j_q + 4'd1;
            end else begin
               i_q <= i_q + 4'd1;
            end
         end
         drain_q <= (state_q == DRAIN) ? drain_q + DW'(1) : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         x0_q <= x0;
         y0_q <= y0;
      end
   end

   assign img_id  = frame_q;
   assign img_id2 = key_q;
   assign img_i   = i_q;
   assign img_j   = {2'b00, j_q};

   // 9-bit sums so anchors near the right/bottom edge never wrap back on screen.
   assign px = {1'b0, x0_q} + {5'b0, i_q};
   assign py = {1'b0, y0_q} + {5'b0, j_q};

   coord_delay #(.LATENCY(LATENCY)) u_coord_delay (
      .clock (clock),
      .reset (reset),
      .vld_i (draw_vld),
      .px_i  (px),
      .py_i  (py),
      .vld_o (vld_dly),
      .px_o  (px_dly),
      .py_o  (py_dly)
   );

   always_comb begin
      plot = vld_dly && (px_dly < 9'(SCREEN_W)) && (py_dly < 9'(SCREEN_H));
`ifdef SPRITE_PLOTTER_TRANSPARENT_EN
      plot = plot && (colour_in != 3'b000);
`else
      plot = plot;
`endif
      x      = px_dly[7:0];
      y      = py_dly[6:0];
      colour = vld_dly ? colour_in : 3'b000;
   end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter with a 2-cycle stub image ROM that
// returns colour = i[2:0]; honours SPRITE_PLOTTER_TRANSPARENT_EN.
module tb_sprite_plotter;

`ifdef SPRITE_PLOTTER_TRANSPARENT_EN
   localparam bit TRANSP = 1'b1;
`else
   localparam bit TRANSP = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset, start;
   logic [7:0] x0, y0;
   logic [2:0] frame;
   logic [1:0] key;
   logic [2:0] colour_in;
   logic [2:0] img_id;
   logic [1:0] img_id2;
   logic [3:0] img_i;
   logic [5:0] img_j;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done;

   int checks = 0;
   int errors = 0;

   sprite_plotter dut (
      .clock(clock), .reset(reset), .start(start), .x0(x0), .y0(y0),
      .frame(frame), .key(key), .colour_in(colour_in),
      .img_id(img_id), .img_id2(img_id2), .img_i(img_i), .img_j(img_j),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   logic [2:0] rom_p0, rom_p1;
   always @(posedge clock) begin
      rom_p0 <= img_i[2:0];
      rom_p1 <= rom_p0;
   end
   assign colour_in = rom_p1;

   task automatic chk(input string name, input int t, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
      end
   endtask

   // Reference: a sprite pixel (i,j) appears iff it lands on screen and,
   // in transparent builds, its colour (i mod 8) is not black.
   function automatic bit pix_on(input int ax, input int ay, input int i, input int j);
      bit on;
      on = ((ax + i) < 160) && ((ay + j) < 120);
      if (TRANSP) on = on && ((i % 8) != 0);
      return on;
   endfunction

   function automatic int count_model(input int ax, input int ay);
      int n = 0;
      for (int j = 0; j < 16; j++)
         for (int i = 0; i < 16; i++)
            if (pix_on(ax, ay, i, j)) n++;
      return n;
   endfunction

   task automatic wait_idle();
      int w = 0;
      @(negedge clock);
      while (busy && w < 400) begin
         @(negedge clock);
         w++;
      end
      if (busy) chk("idle_timeout", w, 1, 0);
   endtask

   task automatic run_sprite(input int ax, input int ay, input int fr, input int kv,
                             output int n, output int fx, output int fy,
                             output int lx, output int ly);
      int k;
      bit ep;
      n = 0; fx = -1; fy = -1; lx = -1; ly = -1;
      wait_idle();
      x0 = 8'(ax); y0 = 8'(ay); frame = 3'(fr); key = 2'(kv);
      start = 1'b1;
      for (int t = 1; t <= 262; t++) begin
         @(negedge clock);
         start = 1'b0;
         chk("busy", t, int'(busy), int'(t <= 259));
         chk("done", t, int'(done), int'(t == 259));
         if (t <= 256) begin
            k = t - 1;
            chk("img_i", t, int'(img_i), k % 16);
            chk("img_j", t, int'(img_j), k / 16);
            chk("img_id", t, int'(img_id), fr);
            chk("img_id2", t, int'(img_id2), kv);
         end
         ep = 1'b0;
         k = 0;
         if (t >= 3 && t <= 258) begin
            k = t - 3;
            ep = pix_on(ax, ay, k % 16, k / 16);
         end
         chk("plot", t, int'(plot), int'(ep));
         if (ep && plot) begin
            chk("x", t, int'(x), ax + k % 16);
            chk("y", t, int'(y), ay + k / 16);
            chk("colour", t, int'(colour), (k % 16) % 8);
         end
         if (plot) begin
            n++;
            if (fx < 0) begin fx = int'(x); fy = int'(y); end
            lx = int'(x); ly = int'(y);
         end
      end
   endtask

   typedef struct {
      int ax, ay, fr, kv;
      int cnt_o, cnt_t, fx_o, fx_t, fy, lx, ly;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n, fx, fy, lx, ly, ecnt, efx, bc;
      int ax, ay;

      vecs[0] = '{10,  20,  0, 0, 256, 224, 10,  11,  20,  25,  35};
      vecs[1] = '{150, 110, 3, 2, 100, 80,  150, 151, 110, 159, 119};
      vecs[2] = '{0,   0,   1, 1, 256, 224, 0,   1,   0,   15,  15};
      vecs[3] = '{159, 119, 7, 3, 1,   0,   159, -1,  119, 159, 119};
      vecs[4] = '{255, 255, 2, 0, 0,   0,   -1,  -1,  -1,  -1,  -1};
      vecs[5] = '{145, 105, 5, 1, 225, 195, 145, 146, 105, 159, 119};

      reset = 1'b1; start = 1'b0; x0 = '0; y0 = '0; frame = '0; key = '0;
      repeat (3) @(negedge clock);
      chk("rst_x", 0, int'(x), 0);
      chk("rst_y", 0, int'(y), 0);
      chk("rst_colour", 0, int'(colour), 0);
      chk("rst_plot", 0, int'(plot), 0);
      chk("rst_busy", 0, int'(busy), 0);
      chk("rst_done", 0, int'(done), 0);
      chk("rst_img_id", 0, int'(img_id), 0);
      chk("rst_img_id2", 0, int'(img_id2), 0);
      chk("rst_img_i", 0, int'(img_i), 0);
      chk("rst_img_j", 0, int'(img_j), 0);
      reset = 1'b0;

      foreach (vecs[v]) begin
         run_sprite(vecs[v].ax, vecs[v].ay, vecs[v].fr, vecs[v].kv, n, fx, fy, lx, ly);
         ecnt = TRANSP ? vecs[v].cnt_t : vecs[v].cnt_o;
         efx  = TRANSP ? vecs[v].fx_t  : vecs[v].fx_o;
         chk("vec_count", v, n, ecnt);
         if (ecnt > 0) begin
            chk("vec_first_x", v, fx, efx);
            chk("vec_first_y", v, fy, vecs[v].fy);
            chk("vec_last_x", v, lx, vecs[v].lx);
            chk("vec_last_y", v, ly, vecs[v].ly);
         end
      end

      // start held high: accepts at N and N+260 only, released before N+520.
      wait_idle();
      x0 = 8'd20; y0 = 8'd30; frame = 3'd4; key = 2'd1;
      start = 1'b1;
      n = 0;
      for (int t = 1; t <= 530; t++) begin
         @(negedge clock);
         if (t == 520) start = 1'b0;
         bc = int'((t <= 259) || (t >= 261 && t <= 519));
         chk("hold_busy", t, int'(busy), bc);
         chk("hold_done", t, int'(done), int'(t == 259 || t == 519));
         if (plot) n++;
      end
      chk("hold_count", 0, n, 2 * count_model(20, 30));

      // Reset mid-draw: nothing plots and no done afterwards.
      wait_idle();
      x0 = 8'd40; y0 = 8'd50; frame = 3'd1; key = 2'd3;
      start = 1'b1;
      for (int t = 1; t <= 400; t++) begin
         @(negedge clock);
         start = 1'b0;
         if (t == 100) reset = 1'b1;
         if (t == 101) reset = 1'b0;
         if (t >= 101) begin
            chk("rst_mid_plot", t, int'(plot), 0);
            chk("rst_mid_busy", t, int'(busy), 0);
            chk("rst_mid_done", t, int'(done), 0);
         end
      end

      for (int r = 0; r < 10; r++) begin
         ax = (r % 2 == 0) ? int'($urandom_range(130, 175)) : int'($urandom_range(0, 255));
         ay = (r % 2 == 0) ? int'($urandom_range(95, 130))  : int'($urandom_range(0, 255));
         run_sprite(ax, ay, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    n, fx, fy, lx, ly);
         chk("rand_count", r, n, count_model(ax, ay));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
